eth_tx_frame_fifo: RTL and testbench
====================================

# eth_tx_frame_fifo

Store-and-forward transmit frame buffer sitting directly upstream of the RGMII MAC transmit stream input. It accepts 8-bit AXI-stream frames from the host side, holds each frame until its last byte has arrived, then releases it to the MAC as one gap-free burst, so the MAC never underruns mid-frame. Frames flagged bad by the source, or frames that overflow the buffer, are discarded whole and counted.

## Interface
- DEPTH, 4096: byte capacity of the buffer; power of two, minimum 2048.
- CNT_W, 16: width of the status counters.

- clk  in  1  125 MHz MAC-side clock; all logic is on this edge.
- rst_n  in  1  synchronous, active-low reset.
- s_axis_tdata  in  8  host frame byte.
- s_axis_tvalid  in  1  host byte valid.
- s_axis_tready  out  1  buffer accepts host byte.
- s_axis_tlast  in  1  last byte of the host frame.
- s_axis_tuser  in  1  bad-frame flag; sampled only on the tlast beat.
- m_axis_tdata  out  8  byte to the MAC transmit stream.
- m_axis_tvalid  out  1  byte valid toward the MAC.
- m_axis_tready  in  1  MAC accepts byte.
- m_axis_tlast  out  1  last byte of the released frame.
- m_axis_tuser  out  1  tied to 0; bad frames are never released.
- frame_cnt  out  CNT_W  frames fully sent to the MAC; saturating.
- drop_cnt  out  CNT_W  frames discarded; saturating.
- overflow  out  1  one-cycle pulse when a frame is discarded for lack of space.

## Operation
- Storage is DEPTH entries of 9 bits: {tlast, tdata}. Pointers are log2(DEPTH)+1 bits wide: wr_ptr (speculative write), wr_commit, rd_ptr.
- Space: used = wr_ptr - rd_ptr, computed modulo 2^(log2(DEPTH)+1). Full when used == DEPTH. Readable data exists when rd_ptr != wr_commit.
- s_axis_tready is 1 whenever rst_n is high. The buffer never back-pressures the host; it drops instead.
- Write state machine:
  - IDLE/RUN: an accepted beat with not-full stores the byte and increments wr_ptr.
  - DROP: entered when a beat arrives while full. That beat and every later beat up to and including tlast are consumed and discarded. wr_ptr is restored to wr_commit. The state returns to RUN after the tlast beat.
  - Commit: a tlast beat accepted in RUN with tuser == 0 stores the byte and sets wr_commit to wr_ptr+1.
  - A tlast beat with tuser == 1 sets wr_ptr back to wr_commit, and nothing is committed.
- Drop accounting:
  - The tuser drop increments drop_cnt by 1.
  - The DROP path increments drop_cnt by 1 on its tlast beat. overflow pulses on the cycle the DROP state is entered.
  - A frame longer than DEPTH always ends in DROP.
- Read side reads memory only below wr_commit, so a partial frame is never exposed.
- frame_cnt increments on each m_axis handshake that has m_axis_tlast == 1.
- Counters saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Reset values:
  - s_axis_tready=0 during reset, 1 afterwards.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0.
  - frame_cnt=0, drop_cnt=0, overflow=0.
  - All pointers 0; write state RUN.
- Commit latency: m_axis_tvalid rises exactly 2 cycles after the cycle in which a committing tlast beat handshakes, provided the buffer was otherwise empty.
- m_axis follows AXI-stream rules:
  - Once m_axis_tvalid is 1, tdata, tlast and tvalid hold until the handshake.
  - tvalid never drops inside a frame.
- Throughput: with m_axis_tready held at 1, one byte is delivered every cycle across the whole frame. Back-to-back committed frames are released with no idle cycle between them. The output register plus a one-entry prefetch/skid stage is required to meet this.
- Simultaneous events:
  - A write and a read in the same cycle are both honoured.
  - "Full" uses rd_ptr from before the read. A read that frees space in cycle N makes that space writable in cycle N+1.
- Commit and read of the last committed byte in the same cycle: the new frame starts without a bubble only if it was committed at least 2 cycles earlier. Otherwise the 2-cycle commit latency applies.
- Reset asserted mid-operation: on the next edge, all stored and partial frames are lost and the outputs take their reset values. No tlast is emitted for a truncated frame.

## Test plan
- Single frame: 64-byte frame 0x00..0x3F, m_axis_tready=1 -> tvalid rises 2 cycles after the input tlast. 64 consecutive beats are emitted, with tlast on byte 0x3F. frame_cnt=1.
- Bad frame: 100-byte frame with tuser=1 on tlast, followed by a good 60-byte frame -> only the 60-byte frame appears on m_axis. drop_cnt=1, overflow never pulses.
- Overflow: DEPTH=2048, m_axis_tready=0, send a 1500-byte frame then a 1000-byte frame -> overflow pulses once, on input byte 549 of the second frame. drop_cnt=1. After raising tready, only the 1500-byte frame is emitted.
- Backpressure: 20-byte frame with m_axis_tready toggling 1,0,0,1 repeatedly -> data and tlast are stable while stalled, all 20 bytes arrive in order, and tvalid has no gap inside the frame.
- Back-to-back: three 60-byte frames sent continuously, tready=1 -> 180 consecutive output beats with tlast on beats 60, 120 and 180. frame_cnt=3.
- Reset mid-frame: rst_n=0 for 1 cycle after 30 of 64 bytes have been output -> tvalid=0 the next cycle and counters=0. A fresh 64-byte frame afterwards passes intact.

Source files
------------

// File: rtl/eth_tx_frame_fifo.sv
// eth_tx_frame_fifo
// Store-and-forward transmit frame buffer in front of the RGMII MAC transmit
// stream. Host frames are written speculatively and only become visible to the
// read side once their last byte arrives without the bad-frame flag. Frames
// that are flagged bad, or that run out of space, are discarded whole and
// counted. The read side feeds the MAC through an output register backed by a
// one-entry skid stage, so committed frames leave as gap-free bursts.

module eth_tx_frame_fifo #(
   parameter int DEPTH = 4096,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   // host side
   input  logic [7:0]       s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic             s_axis_tlast,
   input  logic             s_axis_tuser,
   // MAC side
   output logic [7:0]       m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   output logic             m_axis_tuser,
   // status
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {
      W_RUN  = 1'b0,
      W_DROP = 1'b1
   } wr_state_t;

   // Storage: {tlast, tdata} per entry.
   logic [8:0]    mem [DEPTH];

   // wr_ptr     : speculative write position of the frame being received
   // wr_commit  : end of the last fully accepted frame
   // fetch_ptr  : next entry to move into the output stage
   // rd_ptr     : entries released to the MAC; space is only freed here, so
   //              bytes sitting in the output stage still count as used
   logic [PW-1:0] wr_ptr, wr_ptr_nxt;
   logic [PW-1:0] wr_commit, wr_commit_nxt;
   logic [PW-1:0] fetch_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] used;

   wr_state_t     state, state_nxt;
   logic          beat;
   logic          full;
   logic          mem_we;
   logic          drop_inc;
   logic          overflow_nxt;

   // Output stage: o_* drives the MAC, k_* is the skid entry behind it.
   logic          o_valid;
   logic [8:0]    o_word;
   logic          k_valid;
   logic [8:0]    k_word;
   logic          readable;
   logic          pop;
   logic          fetch;
   logic [8:0]    rd_word;

   // ------------------------------------------------------------------
   // Host side
   // ------------------------------------------------------------------

   // The buffer never back-pressures; it drops frames instead.
   assign s_axis_tready = rst_n;
   assign beat          = s_axis_tvalid & s_axis_tready;
   assign used          = wr_ptr - rd_ptr;
   assign full          = (used == PW'(DEPTH));

   // Write FSM: next state, pointer updates and drop accounting.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch; blocking '=' is correct here.
   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      wr_commit_nxt = wr_commit;
      mem_we        = 1'b0;
      drop_inc      = 1'b0;
      overflow_nxt  = 1'b0;
      unique case (state)
         W_RUN: begin
            if (beat) begin
               if (full) begin
                  // No room: abandon the partial frame and swallow the rest.
                  overflow_nxt = 1'b1;
                  wr_ptr_nxt   = wr_commit;
                  if (s_axis_tlast) begin
                     drop_inc = 1'b1;
                  end else begin
                     state_nxt = W_DROP;
                  end
               end else begin
                  mem_we = 1'b1;
                  if (!s_axis_tlast) begin
                     wr_ptr_nxt = wr_ptr + PW'(1);
                  end else if (s_axis_tuser) begin
                     // Bad frame: rewind, nothing becomes visible.
                     wr_ptr_nxt = wr_commit;
                     drop_inc   = 1'b1;
                  end else begin
                     wr_ptr_nxt    = wr_ptr + PW'(1);
                     wr_commit_nxt = wr_ptr + PW'(1);
                  end
               end
            end
         end
         W_DROP: begin
            if (beat && s_axis_tlast) begin
               state_nxt = W_RUN;
               drop_inc  = 1'b1;
            end
         end
         default: state_nxt = W_RUN;
      endcase
   end

   // Write FSM state register.
   // NOTE: sequential state uses non-blocking '<=' so all registers update
   // together on the edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= W_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Write-side pointers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         wr_commit <= '0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         wr_commit <= wr_commit_nxt;
      end
   end

   // Frame storage write port.
   // NOTE: the storage array is deliberately not reset; the pointers alone
   // decide which entries hold valid data.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   // ------------------------------------------------------------------
   // MAC side
   // ------------------------------------------------------------------

   // Only committed bytes are fetched, so a partial frame is never exposed.
   assign readable = (fetch_ptr != wr_commit);
   assign rd_word  = mem[fetch_ptr[AW-1:0]];
   assign pop      = o_valid & m_axis_tready;
   // Fetch whenever the two-entry output stage will have a free slot.
   assign fetch    = readable & (~(o_valid & k_valid) | pop);

   // Output register plus skid entry; fetch and release pointers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_valid   <= 1'b0;
         o_word    <= '0;
         k_valid   <= 1'b0;
         k_word    <= '0;
         fetch_ptr <= '0;
         rd_ptr    <= '0;
      end else begin
         if (fetch) begin
            fetch_ptr <= fetch_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (pop || !o_valid) begin
            // Output slot frees up: skid entry moves forward first.
            if (k_valid) begin
               o_valid <= 1'b1;
               o_word  <= k_word;
               k_valid <= fetch;
               if (fetch) begin
                  k_word <= rd_word;
               end
            end else begin
               o_valid <= fetch;
               if (fetch) begin
                  o_word <= rd_word;
               end
            end
         end else if (fetch) begin
            // Output stalled: park the fetched byte in the skid entry.
            k_valid <= 1'b1;
            k_word  <= rd_word;
         end
      end
   end

   assign m_axis_tvalid = o_valid;
   assign m_axis_tdata  = o_word[7:0];
   assign m_axis_tlast  = o_word[8];
   assign m_axis_tuser  = 1'b0;

   // ------------------------------------------------------------------
   // Status
   // ------------------------------------------------------------------

   // Saturating frame/drop counters and the overflow pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else begin
         overflow <= overflow_nxt;
         if (pop && o_word[8] && (frame_cnt != '1)) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
         if (drop_inc && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// tb_eth_tx_frame_fifo
// Self-checking bench: directed scenarios followed by randomized frames, all
// compared every cycle against a frame-level reference model (byte queues and
// an occupancy count).

module tb_eth_tx_frame_fifo;

   localparam int DEPTH = 2048;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic [7:0]       s_axis_tdata;
   logic             s_axis_tvalid;
   logic             s_axis_tready;
   logic             s_axis_tlast;
   logic             s_axis_tuser;
   logic [7:0]       m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic             m_axis_tlast;
   logic             m_axis_tuser;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic             overflow;

   eth_tx_frame_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .frame_cnt     (frame_cnt),
      .drop_cnt      (drop_cnt),
      .overflow      (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #4 clk = ~clk;
   end

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: frames as byte queues plus an occupancy count
   // ------------------------------------------------------------------
   typedef struct {
      logic [8:0] b;    // {last, data}
      int         cyc;  // cycle in which the owning frame committed
   } exp_t;

   exp_t       exp_q[$];   // committed bytes not yet taken by the MAC
   logic [8:0] part_q[$];  // frame currently being received
   int         used     = 0;
   bit         dropping = 0;
   bit         exp_ovf  = 0;
   int         m_frames = 0;
   int         m_drops  = 0;
   int         cyc      = 0;
   int         beat_idx = 0;
   int         ovf_beat = 0;
   int         n_ovf    = 0;
   int         n_out    = 0;
   int         run_len  = 0;
   int         run_max  = 0;
   bit         mon_en   = 0;
   bit         prev_hold = 0;
   logic [8:0] prev_word = '0;

   function automatic int sat_inc(input int v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         bit want_valid;
         bit full;
         cyc++;

         // Compare this cycle's outputs with the model.
         check("s_tready", 32'(s_axis_tready), 32'(rst_n));
         check("m_tuser", 32'(m_axis_tuser), 32'd0);
         check("overflow", 32'(overflow), 32'(exp_ovf));
         check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
         check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
         want_valid = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc - 2);
         check("m_tvalid", 32'(m_axis_tvalid), 32'(want_valid));
         if (m_axis_tvalid && exp_q.size() > 0) begin
            check("m_tdata", 32'(m_axis_tdata), 32'(exp_q[0].b[7:0]));
            check("m_tlast", 32'(m_axis_tlast), 32'(exp_q[0].b[8]));
         end
         if (prev_hold) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_word", 32'({m_axis_tlast, m_axis_tdata}), 32'(prev_word));
         end

         // Advance the model by this cycle's handshakes.
         exp_ovf = 0;
         if (!rst_n) begin
            exp_q.delete();
            part_q.delete();
            used      = 0;
            dropping  = 0;
            m_frames  = 0;
            m_drops   = 0;
            beat_idx  = 0;
            prev_hold = 0;
            run_len   = 0;
         end else begin
            full = (used == DEPTH);
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_word = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
               run_len++;
               if (run_len > run_max) run_max = run_len;
               n_out++;
               if (exp_q.size() > 0) begin
                  if (exp_q[0].b[8]) m_frames = sat_inc(m_frames);
                  void'(exp_q.pop_front());
                  used--;
               end
            end else begin
               run_len = 0;
            end
            if (s_axis_tvalid) begin
               beat_idx++;
               if (dropping) begin
                  if (s_axis_tlast) begin
                     dropping = 0;
                     m_drops  = sat_inc(m_drops);
                  end
               end else if (full) begin
                  exp_ovf  = 1;
                  ovf_beat = beat_idx;
                  n_ovf++;
                  used -= part_q.size();
                  part_q.delete();
                  if (s_axis_tlast) m_drops = sat_inc(m_drops);
                  else              dropping = 1;
               end else begin
                  part_q.push_back({s_axis_tlast, s_axis_tdata});
                  used++;
                  if (s_axis_tlast) begin
                     if (s_axis_tuser) begin
                        used -= part_q.size();
                        m_drops = sat_inc(m_drops);
                     end else begin
                        foreach (part_q[i]) exp_q.push_back('{b: part_q[i], cyc: cyc});
                     end
                     part_q.delete();
                  end
               end
               if (s_axis_tlast) beat_idx = 0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // MAC-side ready generator
   // ------------------------------------------------------------------
   int rdy_mode = 0;  // 0: always 1, 1: always 0, 2: 1,0,0,1 pattern, 3: random
   initial begin
      int ph = 0;
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'b0;
            2:       m_axis_tready = (ph == 0) || (ph == 3);
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
         endcase
         ph = (ph + 1) % 4;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic send_frame(input int len, input int base, input bit bad, input int gap_pct);
      for (int i = 0; i < len; i++) begin
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 8'(base + i);
         s_axis_tlast  = (i == len - 1);
         // tuser is meaningful only on the last beat; randomize it elsewhere.
         s_axis_tuser  = (i == len - 1) ? bad : 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic drain(input int limit);
      int g = 0;
      while ((exp_q.size() != 0 || m_axis_tvalid) && g < limit) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("drain_done", 32'(exp_q.size()), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------
   initial begin
      int o0;
      int n0;
      int g;
      rst_n         = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1;

      // Reset values.
      @(negedge clk);
      check("rst_s_tready", 32'(s_axis_tready), 32'd0);
      check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
      check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("run_s_tready", 32'(s_axis_tready), 32'd1);
      @(posedge clk);
      #1;

      // Single 64-byte frame, explicit 2-cycle commit latency.
      rdy_mode = 0;
      send_frame(64, 0, 1'b0, 0);
      @(negedge clk);
      check("lat_cycle1", 32'(m_axis_tvalid), 32'd0);
      @(negedge clk);
      check("lat_cycle2", 32'(m_axis_tvalid), 32'd1);
      @(posedge clk);
      #1;
      drain(200);
      check("single_frame_cnt", 32'(frame_cnt), 32'd1);

      // Bad frame then good frame.
      o0 = n_ovf;
      send_frame(100, 8'h80, 1'b1, 0);
      send_frame(60, 8'h10, 1'b0, 0);
      drain(200);
      check("bad_drop_cnt", 32'(drop_cnt), 32'd1);
      check("bad_frame_cnt", 32'(frame_cnt), 32'd2);
      check("bad_no_overflow", 32'(n_ovf - o0), 32'd0);

      // Overflow with the MAC stalled.
      rdy_mode = 1;
      o0 = n_ovf;
      send_frame(1500, 0, 1'b0, 0);
      send_frame(1000, 8'h55, 1'b0, 0);
      check("ovf_pulses", 32'(n_ovf - o0), 32'd1);
      check("ovf_beat", 32'(ovf_beat), 32'd549);
      check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
      rdy_mode = 0;
      drain(4000);
      check("ovf_frame_cnt", 32'(frame_cnt), 32'd3);

      // Backpressure 1,0,0,1.
      rdy_mode = 2;
      send_frame(20, 8'hA0, 1'b0, 0);
      drain(300);
      check("bp_frame_cnt", 32'(frame_cnt), 32'd4);

      // Three back-to-back frames.
      rdy_mode = 0;
      run_max  = 0;
      send_frame(60, 8'h00, 1'b0, 0);
      send_frame(60, 8'h40, 1'b0, 0);
      send_frame(60, 8'h80, 1'b0, 0);
      drain(400);
      check("b2b_run", 32'(run_max), 32'd180);
      check("b2b_frame_cnt", 32'(frame_cnt), 32'd7);

      // Reset after 30 of 64 bytes have gone out.
      send_frame(64, 8'h40, 1'b0, 0);
      n0 = n_out;
      g  = 0;
      while (n_out - n0 < 30 && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("mid_out_count", 32'(n_out - n0), 32'd30);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
      @(posedge clk);
      #1;
      send_frame(64, 8'hC0, 1'b0, 0);
      drain(200);
      check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
      check("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);

      // Randomized traffic: lengths, bad flags, gaps, MAC stalls, oversize.
      for (int f = 0; f < 40; f++) begin
         int len;
         if (f % 10 == 5) rdy_mode = 1;
         else             rdy_mode = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 2 : 3);
         len = ($urandom_range(0, 7) == 0) ? 2100 : int'($urandom_range(1, 300));
         send_frame(len, int'($urandom_range(0, 255)), 1'($urandom_range(0, 9) == 0), 15);
      end
      rdy_mode = 0;
      drain(6000);
      check("rand_frame_cnt", 32'(frame_cnt), 32'(m_frames));
      check("rand_drop_cnt", 32'(drop_cnt), 32'(m_drops));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound.
   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
